// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline definitions: register index width and the ID/EX payload layout.
package pipe_stage_buf_pkg;

  localparam int REG_W = 5;
  localparam int RS1_W = 32;
  localparam int RS2_W = 32;
  localparam int IMM_W = 25;
  localparam int OP_W  = 7;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic [RS1_W-1:0] rs1;
    logic [RS2_W-1:0] rs2;
    logic [IMM_W-1:0] imm;
    logic [OP_W-1:0]  opcode;
  } id_ex_t;

  localparam int ID_EX_W = $bits(id_ex_t);

endpackage

// File: rtl/pipe_stage_buf_hazard_cmp.sv
// Compares two source indices against every held destination index.
module pipe_hazard_cmp
  import pipe_stage_buf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic [DEPTH-1:0]       held,
  input  logic [DEPTH*REG_W-1:0] rd,
  input  reg_idx_t               rs1,
  input  reg_idx_t               rs2,
  output logic                   hazard
);

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (held[i] &&
          rd[i*REG_W +: REG_W] != '0 &&
          (rd[i*REG_W +: REG_W] == rs1 ||
           rd[i*REG_W +: REG_W] == rs2))
        hazard = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Small FIFO skid buffer between pipeline stages with a
// destination-register hazard check and a starvation counter.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int DATA_W = ID_EX_W,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_W-1:0]        in_data_i,
  input  logic [REG_W-1:0]         in_rd_i,
  input  logic                     flush_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [REG_W-1:0]         out_rd_o,
  input  logic [REG_W-1:0]         rs1_q_i,
  input  logic [REG_W-1:0]         rs2_q_i,
  output logic                     hazard_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [CNT_W-1:0]         bubble_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  reg_idx_t          rd_q   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count;
  logic [CNT_W-1:0] bubble;
  logic             push;
  logic             pop;

  logic [DEPTH-1:0]       held;
  logic [DEPTH*REG_W-1:0] rd_flat;

  assign in_ready_o   = (count != CW'(DEPTH));
  assign out_valid_o  = (count != '0);
  assign push         = in_valid_i & in_ready_o;
  assign pop          = out_valid_o & out_ready_i;
  assign out_data_o   = data_q[rd_ptr];
  assign out_rd_o     = rd_q[rd_ptr];
  assign count_o      = count;
  assign bubble_cnt_o = bubble;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (!push && pop)
        count <= count - CW'(1);
    end
  end

  // Payload storage needs no reset; validity comes from count and pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_ptr] <= in_data_i;
      rd_q[wr_ptr]   <= in_rd_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      bubble <= '0;
    else if (out_ready_i && !out_valid_o && bubble != '1)
      bubble <= bubble + CNT_W'(1);
  end

  // Slot g is held when its distance from the read pointer is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_held
    logic [PTR_W-1:0] off;
    assign off = PTR_W'(g) - rd_ptr;
    assign held[g] = ({1'b0, off} < count);
    assign rd_flat[g*REG_W +: REG_W] = rd_q[g];
  end

  pipe_hazard_cmp #(
    .DEPTH (DEPTH)
  ) u_hazard (
    .held   (held),
    .rd     (rd_flat),
    .rs1    (rs1_q_i),
    .rs2    (rs2_q_i),
    .hazard (hazard_o)
  );

endmodule
